// File: rtl/ex_mem_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_hazard_ctrl_if
// Brief    : Bundle between the 5-stage pipeline datapath and the hazard and
//            stall controller. The master side drives the hazard-detection
//            inputs. The slave side, which is the controller, drives the
//            register hold, flush and status signals.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_hazard_ctrl_if;
    // hazard-detection inputs
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        EX_RegWriteEN;
    logic [1:0]  EX_Mem2RegSEL;
    logic [4:0]  EX_RegWBAddr;
    logic        MEM_Beq;
    logic        MEM_Bne;
    logic        MEM_ZeroFlag;
    logic        MEM_Access;
    logic        MemReady;

    // pipeline controls and status
    logic        PCWriteEN;
    logic        IFID_WriteEN;
    logic        IDEX_WriteEN;
    logic        EXMEM_WriteEN;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        EXMEM_Flush;
    logic        BranchTaken;
    logic        MemTimeout;
    logic [1:0]  State;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    modport master (
        output ID_Rs, ID_Rt, EX_RegWriteEN, EX_Mem2RegSEL, EX_RegWBAddr,
               MEM_Beq, MEM_Bne, MEM_ZeroFlag, MEM_Access, MemReady,
        input  PCWriteEN, IFID_WriteEN, IDEX_WriteEN, EXMEM_WriteEN,
               IFID_Flush, IDEX_Flush, EXMEM_Flush, BranchTaken,
               MemTimeout, State, StallCount, FlushCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, EX_RegWriteEN, EX_Mem2RegSEL, EX_RegWBAddr,
               MEM_Beq, MEM_Bne, MEM_ZeroFlag, MEM_Access, MemReady,
        output PCWriteEN, IFID_WriteEN, IDEX_WriteEN, EXMEM_WriteEN,
               IFID_Flush, IDEX_Flush, EXMEM_Flush, BranchTaken,
               MemTimeout, State, StallCount, FlushCount
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_hazard_ctrl
// Brief    : Hazard and stall controller for the 5-stage MIPS pipeline.
//            - Load-use hazards at ID/EX insert a single bubble.
//            - Resolved branches in EX/MEM flush three pipeline slots.
//            - Multi-cycle memory accesses hold the pipeline. A watchdog
//              forces release after WAIT_MAX wait cycles.
//            Optional macro HAZARD_PERF_CNT_EN builds saturating stall and
//            flush performance counters. Without it, both ports read 0.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    ex_mem_hazard_ctrl_if.slave bus
);

    localparam logic [7:0] c_wait_max = 8'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10,
        ST_UNUSED     = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    logic w_taken;
    logic w_load_use;
    logic w_mem_stall;

    logic w_pc_we;
    logic w_ifid_we;
    logic w_idex_we;
    logic w_exmem_we;
    logic w_ifid_fl;
    logic w_idex_fl;
    logic w_exmem_fl;
    logic w_br_taken;

    assign w_taken     = (bus.MEM_Beq & bus.MEM_ZeroFlag) | (bus.MEM_Bne & ~bus.MEM_ZeroFlag);
    assign w_load_use  = bus.EX_RegWriteEN & (bus.EX_Mem2RegSEL == 2'b01) &
                         (bus.EX_RegWBAddr != 5'd0) &
                         ((bus.EX_RegWBAddr == bus.ID_Rs) | (bus.EX_RegWBAddr == bus.ID_Rt));
    assign w_mem_stall = bus.MEM_Access & ~bus.MemReady;

    // Next-state decode and same-cycle pipeline controls.
    always_comb begin
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_idex_we      = 1'b1;
        w_exmem_we     = 1'b1;
        w_ifid_fl      = 1'b0;
        w_idex_fl      = 1'b0;
        w_exmem_fl     = 1'b0;
        w_br_taken     = 1'b0;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;

        case (r_state)
            ST_RUN, ST_LOAD_STALL: begin
                w_state_nxt = ST_RUN;
                if (w_mem_stall) begin
                    // A memory stall wins even over an (illegal) concurrent branch.
                    w_pc_we        = 1'b0;
                    w_ifid_we      = 1'b0;
                    w_idex_we      = 1'b0;
                    w_exmem_we     = 1'b0;
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end else if (w_taken) begin
                    // The ID instruction is squashed, so any load-use on it is moot.
                    w_br_taken = 1'b1;
                    w_ifid_fl  = 1'b1;
                    w_idex_fl  = 1'b1;
                    w_exmem_fl = 1'b1;
                end else if (w_load_use && (r_state == ST_RUN)) begin
                    w_pc_we     = 1'b0;
                    w_ifid_we   = 1'b0;
                    w_idex_fl   = 1'b1;
                    w_state_nxt = ST_LOAD_STALL;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.MemReady) begin
                    w_state_nxt = ST_RUN;
                end else if (r_wait_cnt == c_wait_max) begin
                    // The watchdog expired, so release as if the memory were ready.
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_RUN;
                end else begin
                    w_pc_we        = 1'b0;
                    w_ifid_we      = 1'b0;
                    w_idex_we      = 1'b0;
                    w_exmem_we     = 1'b0;
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Reset freezes every pipeline register and suppresses all flushes.
    assign bus.PCWriteEN     = RESET_N & w_pc_we;
    assign bus.IFID_WriteEN  = RESET_N & w_ifid_we;
    assign bus.IDEX_WriteEN  = RESET_N & w_idex_we;
    assign bus.EXMEM_WriteEN = RESET_N & w_exmem_we;
    assign bus.IFID_Flush    = RESET_N & w_ifid_fl;
    assign bus.IDEX_Flush    = RESET_N & w_idex_fl;
    assign bus.EXMEM_Flush   = RESET_N & w_exmem_fl;
    assign bus.BranchTaken   = RESET_N & w_br_taken;
    assign bus.MemTimeout    = r_timeout;
    assign bus.State         = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating counts of PC-hold cycles and taken-branch cycles.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!w_pc_we && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_br_taken && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.StallCount = r_stall_cnt;
    assign bus.FlushCount = r_flush_cnt;
`else
    assign bus.StallCount = 16'd0;
    assign bus.FlushCount = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_hazard_ctrl
// Brief    : Self-checking bench for ex_mem_hazard_ctrl. The bench runs
//            directed hazard scenarios and then randomized traffic. Every
//            cycle is checked against a behavioural model of the
//            stall and flush rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 4;

    // {PCWriteEN, IFID_WriteEN, IDEX_WriteEN, EXMEM_WriteEN,
    //  IFID_Flush, IDEX_Flush, EXMEM_Flush, BranchTaken}
    localparam logic [7:0] c_ctl_def   = 8'b1111_0000;
    localparam logic [7:0] c_ctl_hold  = 8'b0000_0000;
    localparam logic [7:0] c_ctl_br    = 8'b1111_1111;
    localparam logic [7:0] c_ctl_lu    = 8'b0011_0100;
    localparam logic [7:0] c_ctl_reset = 8'b0000_0000;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;

    ex_mem_hazard_ctrl_if bus ();

    ex_mem_hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: memory-wait cycles held so far (0 = none),
    // bubble-just-inserted flag, sticky timeout and performance counts.
    int m_wait    = 0;
    bit m_bubble  = 1'b0;
    bit m_timeout = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check this cycle's outputs 1 ns after the falling edge, then advance the model.
    task automatic eval_cycle();
        logic [7:0] got_ctl;
        logic [7:0] exp_ctl;
        logic [1:0] exp_state;
        bit         taken;
        bit         lu;
        bit         ms;
        #1;
        got_ctl = {bus.PCWriteEN, bus.IFID_WriteEN, bus.IDEX_WriteEN, bus.EXMEM_WriteEN,
                   bus.IFID_Flush, bus.IDEX_Flush, bus.EXMEM_Flush, bus.BranchTaken};
        if (!RESET_N) begin
            m_wait = 0; m_bubble = 1'b0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
            check("rst_ctl",     32'(got_ctl),        32'(c_ctl_reset));
            check("rst_state",   32'(bus.State),      32'd0);
            check("rst_timeout", 32'(bus.MemTimeout), 32'd0);
            check("rst_stallc",  32'(bus.StallCount), 32'd0);
            check("rst_flushc",  32'(bus.FlushCount), 32'd0);
        end else begin
            exp_state = (m_wait > 0) ? 2'b10 : (m_bubble ? 2'b01 : 2'b00);
            check("state",   32'(bus.State),      32'(exp_state));
            check("timeout", 32'(bus.MemTimeout), 32'(m_timeout));
            check("stallc",  32'(bus.StallCount), 32'(m_stall));
            check("flushc",  32'(bus.FlushCount), 32'(m_flush));

            taken = (bus.MEM_Beq && bus.MEM_ZeroFlag) || (bus.MEM_Bne && !bus.MEM_ZeroFlag);
            lu    = bus.EX_RegWriteEN && (bus.EX_Mem2RegSEL == 2'b01) && (bus.EX_RegWBAddr != 0) &&
                    ((bus.EX_RegWBAddr == bus.ID_Rs) || (bus.EX_RegWBAddr == bus.ID_Rt));
            ms    = bus.MEM_Access && !bus.MemReady;

            if (m_wait > 0) begin
                m_bubble = 1'b0;
                if (bus.MemReady) begin
                    exp_ctl = c_ctl_def; m_wait = 0;
                end else if (m_wait == int'(WAIT_MAX)) begin
                    exp_ctl = c_ctl_def; m_wait = 0; m_timeout = 1'b1;
                end else begin
                    exp_ctl = c_ctl_hold; m_wait = m_wait + 1;
                end
            end else if (ms) begin
                exp_ctl = c_ctl_hold; m_wait = 1; m_bubble = 1'b0;
            end else if (taken) begin
                exp_ctl = c_ctl_br; m_bubble = 1'b0;
            end else if (lu && !m_bubble) begin
                exp_ctl = c_ctl_lu; m_bubble = 1'b1;
            end else begin
                exp_ctl = c_ctl_def; m_bubble = 1'b0;
            end
            check("ctl", 32'(got_ctl), 32'(exp_ctl));

`ifdef HAZARD_PERF_CNT_EN
            if (!exp_ctl[7] && m_stall < 65535) m_stall = m_stall + 1;
            if (exp_ctl[0]  && m_flush < 65535) m_flush = m_flush + 1;
`endif
        end
    endtask

    task automatic step(input logic rst_n, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rw, input logic [1:0] m2r, input logic [4:0] wb,
                        input logic beq, input logic bne, input logic zf,
                        input logic acc, input logic rdy);
        @(negedge CLOCK);
        RESET_N           = rst_n;
        bus.ID_Rs         = rs;
        bus.ID_Rt         = rt;
        bus.EX_RegWriteEN = rw;
        bus.EX_Mem2RegSEL = m2r;
        bus.EX_RegWBAddr  = wb;
        bus.MEM_Beq       = beq;
        bus.MEM_Bne       = bne;
        bus.MEM_ZeroFlag  = zf;
        bus.MEM_Access    = acc;
        bus.MemReady      = rdy;
        eval_cycle();
    endtask

    task automatic idle();
        step(1'b1, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lowrun = 0;
        logic rdy;

        repeat (2) step(1'b0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // load-use on Rs, then held for a second cycle while the bubble drains
        step(1'b1, 5'd3, 5'd0, 1'b1, 2'b01, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 1'b1, 2'b01, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        // destination r0 never hazards; Rt match does
        step(1'b1, 5'd0, 5'd0, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd7, 1'b1, 2'b01, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        // branches: beq taken, bne with zero not taken, taken branch beats load-use
        step(1'b1, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 1'b1, 2'b01, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        // memory wait of 3 not-ready cycles
        repeat (3) step(1'b1, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        // watchdog: memory never ready
        repeat (6) step(1'b1, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("timeout_sticky", 32'(bus.MemTimeout), 32'd1);
        repeat (3) idle();
        check("timeout_held", 32'(bus.MemTimeout), 32'd1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        // reset aborts a memory wait
        repeat (2) step(1'b1, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // randomized traffic with occasional long not-ready bursts and resets
        for (int i = 0; i < 3000; i++) begin
            if (lowrun == 0 && $urandom_range(0, 59) == 0) lowrun = 8;
            if (lowrun > 0) begin
                rdy = 1'b0;
                lowrun = lowrun - 1;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            step(logic'($urandom_range(0, 199) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), logic'($urandom_range(0, 4) == 0), rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
